// File: rtl/hs_tx_arbiter.sv
// Round-robin arbiter sharing one four-phase handshake transmitter between NREQ requesters.
// Sequences one transfer at a time from the transmitter idle flag and flags stalled transfers.
module hs_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 32,
    parameter int TMO_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      src_req_i,
    input  logic [NREQ*DW-1:0]   src_data_i,
    output logic [NREQ-1:0]      src_done_o,
    input  logic                 tx_idle_i,
    output logic                 tx_req_o,
    output logic [DW-1:0]        tx_data_o,
    output logic                 busy_o,
    output logic [2:0]           grant_id_o,
    output logic                 tmo_o,
    input  logic                 tmo_clr_i
);
    localparam int            CW    = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC + 1);
    localparam logic [CW-1:0] TMO_V = CW'(TMO_CYC);

    // state      | meaning
    // ARB        | waiting for transmitter idle and an eligible request
    // WAIT_START | request issued, waiting for the transmitter to leave idle
    // WAIT_DONE  | transfer in flight, waiting for the transmitter to return to idle
    typedef enum logic [2:0] {
        ARB        = 3'b001,
        WAIT_START = 3'b010,
        WAIT_DONE  = 3'b100
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [2:0]      grant_id_q, grant_id_d;
    logic            tx_req_q, tx_req_d;
    logic [DW-1:0]   tx_data_q, tx_data_d;
    logic            busy_q, busy_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            tmo_q, tmo_d;
    logic [CW-1:0]   wd_q, wd_d;

    logic [NREQ-1:0] elig;
    logic            found;
    logic [2:0]      win;
    logic [DW-1:0]   win_data;
    logic            tmo_set;
    int              off;
    int              best_off;

    // The requester just served is still holding its request during the done cycle.
    always_comb begin : pick
        elig     = src_req_i & ~done_q;
        win      = '0;
        win_data = '0;
        best_off = NREQ;
        off      = 0;
        for (int k = 0; k < NREQ; k++) begin
            off = (k + NREQ - int'(ptr_q)) % NREQ;
            if (elig[k] && off < best_off) begin
                best_off = off;
                win      = 3'(k);
                win_data = src_data_i[k*DW +: DW];
            end
        end
        found = (best_off < NREQ);
    end

    always_comb begin : next
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        tx_data_d  = tx_data_q;
        tx_req_d   = 1'b0;
        busy_d     = busy_q;
        done_d     = '0;
        wd_d       = wd_q;
        tmo_set    = 1'b0;
        unique case (state_q)
            ARB: begin
                if (tx_idle_i && found) begin
                    grant_id_d = win;
                    tx_data_d  = win_data;
                    tx_req_d   = 1'b1;
                    busy_d     = 1'b1;
                    wd_d       = '0;
                    ptr_d      = (int'(win) == NREQ - 1) ? 3'd0 : win + 3'd1;
                    state_d    = WAIT_START;
                end
            end
            WAIT_START: begin
                if (!tx_idle_i) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_idle_i) begin
                    for (int k = 0; k < NREQ; k++) begin
                        if (grant_id_q == 3'(k)) done_d[k] = 1'b1;
                    end
                    busy_d  = 1'b0;
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
        // Watchdog only reports; the transfer keeps waiting on the transmitter.
        if (state_q != ARB && TMO_CYC != 0 && wd_q != TMO_V) begin
            wd_d    = wd_q + CW'(1);
            tmo_set = (wd_d == TMO_V);
        end
        tmo_d = tmo_set | (tmo_q & ~tmo_clr_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB;
            ptr_q      <= '0;
            grant_id_q <= '0;
            tx_req_q   <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= '0;
            tmo_q      <= 1'b0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            tx_req_q   <= tx_req_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tmo_q      <= tmo_d;
            wd_q       <= wd_d;
        end
    end

    assign src_done_o = done_q;
    assign tx_req_o   = tx_req_q;
    assign tx_data_o  = tx_data_q;
    assign busy_o     = busy_q;
    assign grant_id_o = grant_id_q;
    assign tmo_o      = tmo_q;

endmodule

// File: tb/tb_hs_tx_arbiter.sv
// Bench for hs_tx_arbiter: transaction-level reference model, a simple transmitter model,
// directed scenarios followed by randomized requests and transfer lengths.
module tb_hs_tx_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int TMO  = 16;

    logic                clk   = 1'b0;
    logic                rst   = 1'b1;
    logic [NREQ-1:0]     req_r = '0;
    logic [DW-1:0]       data_r [NREQ];
    logic [NREQ*DW-1:0]  src_data;
    logic                idle_r = 1'b1;
    logic                clr_r  = 1'b0;

    logic [NREQ-1:0]     src_done_o;
    logic                tx_req_o;
    logic [DW-1:0]       tx_data_o;
    logic                busy_o;
    logic [2:0]          grant_id_o;
    logic                tmo_o;

    int total = 0;
    int bad   = 0;

    // reference model state
    int          m_ptr, m_id, m_wd;
    bit          m_inflight, m_started, m_tmo, m_req;
    logic [3:0]  m_done, m_mask;
    logic [31:0] m_data;

    // environment state
    bit          drop_on_done = 1'b1;
    bit          force_low    = 1'b0;
    logic [3:0]  pend_drop    = '0;
    int          tx_left      = 0;
    int          tx_dur       = 2;

    int          grants[$];
    logic [31:0] gdata[$];
    logic [3:0]  dones[$];

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NREQ; k++) src_data[k*DW +: DW] = data_r[k];
    end

    hs_tx_arbiter #(.NREQ(NREQ), .DW(DW), .TMO_CYC(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_req_i  (req_r),
        .src_data_i (src_data),
        .src_done_o (src_done_o),
        .tx_idle_i  (idle_r),
        .tx_req_o   (tx_req_o),
        .tx_data_o  (tx_data_o),
        .busy_o     (busy_o),
        .grant_id_o (grant_id_o),
        .tmo_o      (tmo_o),
        .tmo_clr_i  (clr_r)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_ptr = 0; m_id = 0; m_wd = 0;
        m_inflight = 0; m_started = 0; m_tmo = 0; m_req = 0;
        m_done = '0; m_mask = '0; m_data = '0;
    endtask

    // Advance the model by one rising edge, using the inputs that edge saw.
    task automatic model_step();
        logic [3:0] elig;
        int w, c;
        bit set_t;
        m_req  = 0;
        m_done = '0;
        set_t  = 0;
        if (rst) begin
            m_reset();
            return;
        end
        if (!m_inflight) begin
            elig   = req_r & ~m_mask;
            m_mask = '0;
            if (idle_r && elig != 0) begin
                w = -1;
                for (int k = 0; k < NREQ; k++) begin
                    c = (m_ptr + k) % NREQ;
                    if (w < 0 && elig[c]) w = c;
                end
                m_id       = w;
                m_data     = data_r[w];
                m_req      = 1;
                m_ptr      = (w + 1) % NREQ;
                m_inflight = 1;
                m_started  = 0;
                m_wd       = 0;
            end
        end else begin
            if (m_wd < TMO) begin
                m_wd++;
                if (m_wd == TMO) set_t = 1;
            end
            if (!m_started) begin
                if (!idle_r) m_started = 1;
            end else if (idle_r) begin
                m_done     = 4'(1 << m_id);
                m_inflight = 0;
                m_mask     = m_done;
            end
        end
        if (set_t) m_tmo = 1;
        else if (clr_r) m_tmo = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        chk("tx_req",   64'(tx_req_o),   64'(m_req));
        chk("tx_data",  64'(tx_data_o),  64'(m_data));
        chk("busy",     64'(busy_o),     64'(m_inflight));
        chk("grant_id", 64'(grant_id_o), 64'(m_id));
        chk("done",     64'(src_done_o), 64'(m_done));
        chk("tmo",      64'(tmo_o),      64'(m_tmo));
        if (tx_req_o) begin
            grants.push_back(int'(grant_id_o));
            gdata.push_back(tx_data_o);
        end
        if (src_done_o != 0) dones.push_back(src_done_o);
        if (drop_on_done) req_r &= ~pend_drop;
        pend_drop = m_done;
        if (tx_left > 0) tx_left--;
        if (tx_req_o) tx_left = tx_dur;
        idle_r = !force_low && (tx_left == 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_tx_req",   64'(tx_req_o),   64'd0);
        chk("rst_busy",     64'(busy_o),     64'd0);
        chk("rst_done",     64'(src_done_o), 64'd0);
        chk("rst_grant_id", 64'(grant_id_o), 64'd0);
        chk("rst_tx_data",  64'(tx_data_o),  64'd0);
        chk("rst_tmo",      64'(tmo_o),      64'd0);
        tx_left   = 0;
        force_low = 0;
        pend_drop = '0;
        idle_r    = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n0, d0, g_at, first_tmo;
        int exp_t2[5];
        int exp_t3[3];
        logic [3:0] exp_d2[5];
        for (int k = 0; k < NREQ; k++) data_r[k] = '0;
        m_reset();
        run(3);
        rst = 1'b0;

        // single requester, 10-cycle transfer
        data_r[0] = 32'hA5A5_0001;
        req_r     = 4'b0001;
        tx_dur    = 10;
        run(16);
        chk("t1_ngrant", 64'(grants.size()), 64'd1);
        if (grants.size() > 0) begin
            chk("t1_id",   64'(grants[0]), 64'd0);
            chk("t1_data", 64'(gdata[0]),  64'hA5A5_0001);
        end
        chk("t1_ndone", 64'(dones.size()), 64'd1);
        if (dones.size() > 0) chk("t1_done", 64'(dones[0]), 64'b0001);

        // all four requesting continuously from reset
        do_reset();
        grants.delete(); gdata.delete(); dones.delete();
        drop_on_done = 0;
        for (int k = 0; k < NREQ; k++) data_r[k] = 32'h1000_0000 + 32'(k);
        req_r  = 4'b1111;
        tx_dur = 2;
        run(22);
        exp_t2 = '{0, 1, 2, 3, 0};
        exp_d2 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        chk("t2_ngrant", 64'(grants.size() >= 5), 64'd1);
        chk("t2_ndone",  64'(dones.size() >= 5),  64'd1);
        for (int i = 0; i < 5; i++) begin
            if (i < grants.size()) chk("t2_order", 64'(grants[i]), 64'(exp_t2[i]));
            if (i < dones.size())  chk("t2_done",  64'(dones[i]),  64'(exp_d2[i]));
        end
        req_r = '0;
        run(8);

        // requests 0110 after serving requester 2
        drop_on_done = 1;
        do_reset();
        grants.delete(); gdata.delete(); dones.delete();
        data_r[2] = 32'h2222_0002;
        req_r     = 4'b0100;
        run(6);
        data_r[1] = 32'h1111_0001;
        req_r     = 4'b0110;
        run(12);
        exp_t3 = '{2, 1, 2};
        chk("t3_ngrant", 64'(grants.size()), 64'd3);
        for (int i = 0; i < 3; i++)
            if (i < grants.size()) chk("t3_order", 64'(grants[i]), 64'(exp_t3[i]));

        // idle blocking, then watchdog on a stalled transfer
        n0        = grants.size();
        d0        = dones.size();
        force_low = 1;
        idle_r    = 1'b0;
        data_r[0] = 32'hC0DE_0004;
        req_r     = 4'b0001;
        run(5);
        chk("t4_blocked", 64'(grants.size()), 64'(n0));
        force_low = 0;
        idle_r    = 1'b1;
        tx_dur    = 25;
        g_at      = -1;
        first_tmo = -1;
        for (int i = 0; i < 45; i++) begin
            tick();
            if (tx_req_o && g_at < 0) g_at = i;
            if (g_at >= 0 && tmo_o && first_tmo < 0) first_tmo = i - g_at;
        end
        chk("t4_granted",  64'(g_at >= 0),     64'd1);
        chk("t4_tmo_rise", 64'(first_tmo),     64'd16);
        chk("t4_sticky",   64'(tmo_o),         64'd1);
        chk("t4_ndone",    64'(dones.size()),  64'(d0 + 1));
        if (dones.size() > d0) chk("t4_done", 64'(dones[d0]), 64'b0001);
        clr_r = 1'b1;
        tick();
        clr_r = 1'b0;
        chk("t4_clr", 64'(tmo_o), 64'd0);

        // reset during WAIT_DONE, pending request re-granted from ptr=0
        data_r[2] = 32'h5555_0005;
        req_r     = 4'b0100;
        tx_dur    = 20;
        run(4);
        data_r[3] = 32'h3333_0003;
        req_r     = 4'b1100;
        grants.delete(); gdata.delete(); dones.delete();
        do_reset();
        tx_dur = 3;
        run(20);
        chk("t5_ngrant", 64'(grants.size()), 64'd2);
        if (grants.size() > 0) chk("t5_first", 64'(grants[0]), 64'd2);
        if (grants.size() > 1) chk("t5_second", 64'(grants[1]), 64'd3);
        if (dones.size() > 0)  chk("t5_done0", 64'(dones[0]), 64'b0100);

        // randomized requests, payloads, transfer lengths, idle blips, clears
        for (int i = 0; i < 400; i++) begin
            tick();
            tx_dur = int'($urandom_range(5, 1));
            for (int k = 0; k < NREQ; k++) begin
                if (!req_r[k] && $urandom_range(2) == 0) begin
                    req_r[k]  = 1'b1;
                    data_r[k] = $urandom;
                end
            end
            force_low = (tx_left == 0) && ($urandom_range(4) == 0);
            clr_r     = ($urandom_range(7) == 0);
            idle_r    = !force_low && (tx_left == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
